// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, datapath width and
// word-alignment helpers, also used by the program counter and decode.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fq_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_ADDR_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO of {pc, instr} pairs with flush; the head entry
// is presented combinationally so decode sees it without added latency.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [63:0]                wdata_i,
  output logic [63:0]                rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_C) || do_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      // Redirect wins over any push or pop in the same cycle.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: single-outstanding memory read FSM feeding a small
// {pc, instr} queue, and the enable for the program counter register.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] PC,
  output logic        PC_EN,
  input  logic        FLUSH,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RDY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INSTR_VALID,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  input  logic        INSTR_READY
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fq_state_e     state_q;
  logic [31:0]   req_pc_q;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic          accept;
  logic          push;
  logic          pop;

  // Space is reserved at issue time, so a returning push never overflows.
  assign IMEM_REQ  = RESET_N && (state_q == IDLE) && !FLUSH && (count < DEPTH_C);
  assign accept    = IMEM_REQ && IMEM_RDY;
  assign PC_EN     = RESET_N && (FLUSH || accept);
  assign IMEM_ADDR = word_align(PC);

  assign push = (state_q == WAIT) && IMEM_RVALID && !FLUSH;
  assign pop  = INSTR_VALID && INSTR_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= WAIT;
            req_pc_q <= PC;
          end
        end
        WAIT: begin
          if (IMEM_RVALID) begin
            state_q <= IDLE;
          end else if (FLUSH) begin
            state_q <= DISCARD;
          end
        end
        DISCARD: begin
          if (IMEM_RVALID) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RESET_N),
    .flush_i (FLUSH),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({req_pc_q, IMEM_RDATA}),
    .rdata_o (head),
    .count_o (count)
  );

  assign INSTR_VALID = (count != '0);
  assign INSTR       = head[31:0];
  assign INSTR_PC    = head[63:32];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model;
// the bench also plays the PC register and a variable-latency memory.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] PC;
  logic        PC_EN;
  logic        FLUSH;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDY;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_READY;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .PC          (PC),
    .PC_EN       (PC_EN),
    .FLUSH       (FLUSH),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_RDY    (IMEM_RDY),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
    .INSTR_VALID (INSTR_VALID),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .INSTR_READY (INSTR_READY)
  );

  always #5 CLK = ~CLK;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: entries awaiting decode, plus one in-flight read that
  // may have been made stale by a redirect.
  logic [63:0] q[$];
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_req_pc;

  // Environment: PC register next value and the memory's pending response.
  logic [31:0] pc_nxt;
  logic [31:0] flush_tgt;
  bit          mem_pend;
  int unsigned mem_cnt;

  int unsigned p_rdy, p_flush, p_ready, p_spur, lat_max;
  bit exp_req, exp_acc, exp_pop;

  task automatic step(input bit rst_n_val);
    bit took;
    @(negedge CLK);
    RESET_N     = rst_n_val;
    PC          = pc_nxt;
    IMEM_RDY    = ($urandom_range(99) < p_rdy);
    FLUSH       = ($urandom_range(99) < p_flush);
    INSTR_READY = ($urandom_range(99) < p_ready);
    flush_tgt   = $urandom;
    IMEM_RDATA  = $urandom;
    IMEM_RVALID = 1'b0;
    if (mem_pend) begin
      if (mem_cnt > 0) mem_cnt--;
      if (mem_cnt == 0) IMEM_RVALID = 1'b1;
      // An abandoned (pre-reset) read is still in the memory: hold off new ones.
      if (!m_out) IMEM_RDY = 1'b0;
    end else if (!m_out && ($urandom_range(99) < p_spur)) begin
      IMEM_RVALID = 1'b1;
    end
    #1;
    if (!RESET_N) begin
      check("rst_imem_req", IMEM_REQ, 0);
      check("rst_pc_en", PC_EN, 0);
      check("rst_instr_valid", INSTR_VALID, 0);
      check("rst_instr", INSTR, 0);
      check("rst_instr_pc", INSTR_PC, 0);
    end else begin
      exp_req = !m_out && !FLUSH && (q.size() < DEPTH);
      exp_acc = exp_req && IMEM_RDY;
      exp_pop = (q.size() != 0) && INSTR_READY;
      check("imem_req", IMEM_REQ, exp_req);
      check("pc_en", PC_EN, FLUSH || exp_acc);
      check("imem_addr", IMEM_ADDR, PC & ~32'h3);
      check("instr_valid", INSTR_VALID, q.size() != 0);
      if (q.size() != 0) begin
        check("instr", INSTR, q[0][31:0]);
        check("instr_pc", INSTR_PC, q[0][63:32]);
      end
    end
    @(posedge CLK);
    if (IMEM_RVALID && mem_pend && mem_cnt == 0) mem_pend = 0;
    if (!RESET_N) begin
      q.delete();
      m_out    = 0;
      m_stale  = 0;
      m_req_pc = '0;
    end else begin
      took = m_out && !m_stale && IMEM_RVALID && !FLUSH;
      if (FLUSH) begin
        q.delete();
      end else begin
        if (exp_pop) void'(q.pop_front());
        if (took) q.push_back({m_req_pc, IMEM_RDATA});
      end
      if (m_out) begin
        if (IMEM_RVALID) m_out = 0;
        else if (FLUSH) m_stale = 1;
      end else if (exp_acc) begin
        m_out    = 1;
        m_stale  = 0;
        m_req_pc = PC;
        mem_pend = 1;
        mem_cnt  = $urandom_range(lat_max, 1);
      end
      if (FLUSH) pc_nxt = flush_tgt;
      else if (exp_acc) pc_nxt = PC + 32'd4;
    end
  endtask

  task automatic run_phase(input int unsigned n, input int unsigned rdy, input int unsigned fl,
                           input int unsigned rd, input int unsigned lat, input int unsigned spur);
    p_rdy = rdy; p_flush = fl; p_ready = rd; lat_max = lat; p_spur = spur;
    for (int unsigned i = 0; i < n; i++) step(1'b1);
  endtask

  // Abandon an in-flight read with reset; its data returns just after release.
  task automatic reset_mid_wait();
    int unsigned budget;
    p_rdy = 100; p_flush = 0; p_ready = 50; lat_max = 3; p_spur = 0;
    budget = 0;
    while (!m_out && budget < 50) begin
      step(1'b1);
      budget++;
    end
    check("reach_wait", m_out, 1);
    mem_pend = 1;
    mem_cnt  = 3;
    step(1'b0);
    step(1'b0);
    for (int unsigned i = 0; i < 10; i++) step(1'b1);
  endtask

  initial begin
    RESET_N = 1'b0; PC = '0; FLUSH = 1'b0; IMEM_RDY = 1'b0;
    IMEM_RVALID = 1'b0; IMEM_RDATA = '0; INSTR_READY = 1'b0;
    pc_nxt = 32'h0; mem_pend = 0; mem_cnt = 0;
    m_out = 0; m_stale = 0; m_req_pc = '0;
    p_rdy = 0; p_flush = 30; p_ready = 50; lat_max = 1; p_spur = 30;
    for (int unsigned i = 0; i < 3; i++) step(1'b0);

    run_phase(40, 100, 0, 100, 1, 0);    // steady 1-cycle memory
    run_phase(60, 100, 0, 15, 1, 0);     // decode backpressure
    run_phase(300, 80, 20, 60, 3, 10);   // frequent redirects
    run_phase(300, 30, 5, 50, 3, 10);    // slow memory, wait states
    run_phase(400, 60, 10, 70, 2, 5);    // mixed
    for (int unsigned k = 0; k < 3; k++) reset_mid_wait();
    run_phase(200, 70, 8, 60, 3, 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
